// File: rtl/wb_splitter_n.sv
// Wishbone classic splitter: one master fanned out to NUM_SLAVES slaves by base/mask decode.
// Optional slave timeout abort is built only when WB_SPLITTER_TIMEOUT_EN is defined.
module wb_splitter_n #(
    parameter int unsigned                 NUM_SLAVES = 4,
    parameter int unsigned                 AW         = 32,
    parameter int unsigned                 DW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0]    BASE_ADDR  = {32'h3003_0000, 32'h3002_0000,
                                                         32'h3001_0000, 32'h3000_0000},
    parameter logic [AW-1:0]               ADDR_MASK  = 32'hFFFF_0000,
    parameter int unsigned                 TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AW-1:0]            m_wb_adr,
    input  logic [DW-1:0]            m_wb_dat_w,
    input  logic [DW/8-1:0]          m_wb_sel,
    input  logic                     m_wb_we,
    input  logic                     m_wb_cyc,
    input  logic                     m_wb_stb,
    output logic [DW-1:0]            m_wb_dat_r,
    output logic                     m_wb_ack,
    output logic                     m_wb_err,
    output logic [AW-1:0]            s_wb_adr,
    output logic [DW-1:0]            s_wb_dat_w,
    output logic [DW/8-1:0]          s_wb_sel,
    output logic                     s_wb_we,
    output logic [NUM_SLAVES-1:0]    s_wb_cyc,
    output logic [NUM_SLAVES-1:0]    s_wb_stb,
    input  logic [NUM_SLAVES*DW-1:0] s_wb_dat_r,
    input  logic [NUM_SLAVES-1:0]    s_wb_ack,
    input  logic [NUM_SLAVES-1:0]    s_wb_err,
    output logic                     timeout_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   slv_q, slv_d;
    logic [AW-1:0]           adr_q, adr_d;
    logic [DW-1:0]           dat_w_q, dat_w_d;
    logic [DW/8-1:0]         be_q, be_d;
    logic                    we_q, we_d;
    logic [DW-1:0]           dat_r_q, dat_r_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    tmo_q, tmo_d;

    logic [NUM_SLAVES-1:0]   hit;
    logic                    hit_found;
    logic                    slv_ack;
    logic                    slv_err;
    logic [DW-1:0]           slv_dat;
    logic                    tmo_fire;

    // Priority decode: the lowest matching slave index wins.
    always_comb begin
        hit       = '0;
        hit_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit_found &&
                ((m_wb_adr & ADDR_MASK) == (BASE_ADDR[i*AW +: AW] & ADDR_MASK))) begin
                hit[i]    = 1'b1;
                hit_found = 1'b1;
            end
        end
    end

    always_comb begin
        slv_dat = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (slv_q[i]) slv_dat = slv_dat | s_wb_dat_r[i*DW +: DW];
        end
    end

    assign slv_ack = |(s_wb_ack & slv_q);
    assign slv_err = |(s_wb_err & slv_q);

`ifdef WB_SPLITTER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero outside BUSY, so the first BUSY cycle always counts from 0.
    always_comb begin
        cnt_d = '0;
        if (state_q == BUSY) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tmo_fire = (state_q == BUSY) && (cnt_q == CNT_LAST);
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        slv_d   = slv_q;
        adr_d   = adr_q;
        dat_w_d = dat_w_q;
        be_d    = be_q;
        we_d    = we_q;
        dat_r_d = dat_r_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m_wb_cyc && m_wb_stb) begin
                    adr_d   = m_wb_adr;
                    dat_w_d = m_wb_dat_w;
                    be_d    = m_wb_sel;
                    we_d    = m_wb_we;
                    if (hit_found) begin
                        slv_d   = hit;
                        state_d = BUSY;
                    end else begin
                        err_d   = 1'b1;
                        dat_r_d = '0;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (!m_wb_cyc) begin
                    slv_d   = '0;
                    state_d = IDLE;
                end else if (slv_ack) begin
                    dat_r_d = slv_dat;
                    ack_d   = 1'b1;
                    slv_d   = '0;
                    state_d = RESP;
                end else if (slv_err || tmo_fire) begin
                    dat_r_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = !slv_err;
                    slv_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            slv_q   <= '0;
            adr_q   <= '0;
            dat_w_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            dat_r_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slv_q   <= slv_d;
            adr_q   <= adr_d;
            dat_w_q <= dat_w_d;
            be_q    <= be_d;
            we_q    <= we_d;
            dat_r_q <= dat_r_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign s_wb_cyc   = (state_q == BUSY) ? slv_q : '0;
    assign s_wb_stb   = (state_q == BUSY) ? slv_q : '0;
    assign s_wb_adr   = adr_q;
    assign s_wb_dat_w = dat_w_q;
    assign s_wb_sel   = be_q;
    assign s_wb_we    = we_q;
    assign m_wb_dat_r = dat_r_q;
    assign m_wb_ack   = ack_q;
    assign m_wb_err   = err_q;
    assign timeout_o  = tmo_q;

endmodule

// File: tb/tb_wb_splitter_n.sv
// Directed self-checking bench for wb_splitter_n (4 slaves, default map, TIMEOUT=8).
// Covers both builds of WB_SPLITTER_TIMEOUT_EN.
module tb_wb_splitter_n;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     m_wb_adr = '0;
    logic [DW-1:0]     m_wb_dat_w = '0;
    logic [DW/8-1:0]   m_wb_sel = '0;
    logic              m_wb_we = 1'b0;
    logic              m_wb_cyc = 1'b0;
    logic              m_wb_stb = 1'b0;
    logic [DW-1:0]     m_wb_dat_r;
    logic              m_wb_ack;
    logic              m_wb_err;
    logic [AW-1:0]     s_wb_adr;
    logic [DW-1:0]     s_wb_dat_w;
    logic [DW/8-1:0]   s_wb_sel;
    logic              s_wb_we;
    logic [NS-1:0]     s_wb_cyc;
    logic [NS-1:0]     s_wb_stb;
    logic [NS*DW-1:0]  s_wb_dat_r = '0;
    logic [NS-1:0]     s_wb_ack = '0;
    logic [NS-1:0]     s_wb_err = '0;
    logic              timeout_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    wb_splitter_n #(
        .NUM_SLAVES (NS),
        .AW         (AW),
        .DW         (DW),
        .TIMEOUT    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_wb_adr   (m_wb_adr),
        .m_wb_dat_w (m_wb_dat_w),
        .m_wb_sel   (m_wb_sel),
        .m_wb_we    (m_wb_we),
        .m_wb_cyc   (m_wb_cyc),
        .m_wb_stb   (m_wb_stb),
        .m_wb_dat_r (m_wb_dat_r),
        .m_wb_ack   (m_wb_ack),
        .m_wb_err   (m_wb_err),
        .s_wb_adr   (s_wb_adr),
        .s_wb_dat_w (s_wb_dat_w),
        .s_wb_sel   (s_wb_sel),
        .s_wb_we    (s_wb_we),
        .s_wb_cyc   (s_wb_cyc),
        .s_wb_stb   (s_wb_stb),
        .s_wb_dat_r (s_wb_dat_r),
        .s_wb_ack   (s_wb_ack),
        .s_wb_err   (s_wb_err),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; all sampling and driving happens 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [DW/8-1:0] sel, input logic we);
        m_wb_adr   = adr;
        m_wb_dat_w = dat;
        m_wb_sel   = sel;
        m_wb_we    = we;
        m_wb_cyc   = 1'b1;
        m_wb_stb   = 1'b1;
    endtask

    task automatic release_bus();
        m_wb_cyc = 1'b0;
        m_wb_stb = 1'b0;
        s_wb_ack = '0;
        s_wb_err = '0;
    endtask

    initial begin
        int unsigned n;
        logic        seen;

        #1;
        check("rst_ack",   m_wb_ack, 1'b0);
        check("rst_err",   m_wb_err, 1'b0);
        check("rst_stb",   s_wb_stb, 4'b0000);
        check("rst_dat_r", m_wb_dat_r, 32'h0);
        check("rst_tmo",   timeout_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Write slave 1, zero-wait ack
        request(32'h3001_0004, 32'hDEAD_BEEF, 4'hF, 1'b1);
        tick();
        check("wr_stb",   s_wb_stb, 4'b0010);
        check("wr_cyc",   s_wb_cyc, 4'b0010);
        check("wr_adr",   s_wb_adr, 32'h3001_0004);
        check("wr_dat",   s_wb_dat_w, 32'hDEAD_BEEF);
        check("wr_sel",   s_wb_sel, 4'hF);
        check("wr_we",    s_wb_we, 1'b1);
        check("wr_ack_early", m_wb_ack, 1'b0);
        s_wb_ack = 4'b0010;
        tick();
        check("wr_ack",   m_wb_ack, 1'b1);
        check("wr_err",   m_wb_err, 1'b0);
        check("wr_stb_off", s_wb_stb, 4'b0000);
        release_bus();
        tick();
        check("wr_ack_once", m_wb_ack, 1'b0);

        // Read slave 3 with 4 wait cycles; other lanes carry junk
        request(32'h3003_0008, 32'h0, 4'hF, 1'b0);
        s_wb_dat_r = {32'h1234_5678, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF};
        tick();
        check("rd_stb", s_wb_stb, 4'b1000);
        check("rd_we",  s_wb_we, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("rd_wait_ack", m_wb_ack, 1'b0);
            tick();
        end
        check("rd_stb_held", s_wb_stb, 4'b1000);
        s_wb_ack = 4'b1000;
        tick();
        check("rd_ack", m_wb_ack, 1'b1);
        check("rd_dat", m_wb_dat_r, 32'h1234_5678);
        release_bus();
        tick();
        check("rd_dat_hold", m_wb_dat_r, 32'h1234_5678);
        check("rd_ack_once", m_wb_ack, 1'b0);

        // Unmapped address
        request(32'h3004_0000, 32'h0, 4'hF, 1'b0);
        tick();
        check("um_stb", s_wb_stb, 4'b0000);
        check("um_err", m_wb_err, 1'b1);
        check("um_ack", m_wb_ack, 1'b0);
        check("um_dat", m_wb_dat_r, 32'h0);
        release_bus();
        tick();
        check("um_err_once", m_wb_err, 1'b0);
        check("um_stb_idle", s_wb_stb, 4'b0000);

        // Slave 2: ack and err together, ack wins
        request(32'h3002_0010, 32'h0, 4'hF, 1'b0);
        s_wb_dat_r = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
        tick();
        check("pr_stb", s_wb_stb, 4'b0100);
        s_wb_ack = 4'b0100;
        s_wb_err = 4'b0100;
        tick();
        check("pr_ack", m_wb_ack, 1'b1);
        check("pr_err", m_wb_err, 1'b0);
        check("pr_dat", m_wb_dat_r, 32'hCAFE_F00D);
        release_bus();
        tick();

        // Slave 2: err alone clears read data
        request(32'h3002_0014, 32'h0, 4'hF, 1'b0);
        tick();
        s_wb_err = 4'b0100;
        tick();
        check("se_err", m_wb_err, 1'b1);
        check("se_ack", m_wb_ack, 1'b0);
        check("se_dat", m_wb_dat_r, 32'h0);
        release_bus();
        tick();

        // Slave 0 never responds
        request(32'h3000_0000, 32'h0, 4'hF, 1'b0);
        tick();
`ifdef WB_SPLITTER_TIMEOUT_EN
        n = 0;
        while (s_wb_stb[0] && n < 50) begin
            n++;
            tick();
        end
        check("to_stb_cycles", 64'(n), 64'd8);
        check("to_err", m_wb_err, 1'b1);
        check("to_pulse", timeout_o, 1'b1);
        release_bus();
        tick();
        check("to_pulse_once", timeout_o, 1'b0);
        check("to_err_once", m_wb_err, 1'b0);
`else
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (m_wb_ack || m_wb_err || timeout_o || !s_wb_stb[0]) seen = 1'b1;
            tick();
        end
        check("nt_no_resp", seen, 1'b0);
        check("nt_stb", s_wb_stb, 4'b0001);
        release_bus();
        tick();
        check("nt_abort_stb", s_wb_stb, 4'b0000);
`endif

        // Master drops cyc in BUSY, then a fresh request completes
        request(32'h3001_0020, 32'h0000_00A5, 4'h1, 1'b1);
        tick();
        check("ab_stb", s_wb_stb, 4'b0010);
        release_bus();
        tick();
        check("ab_stb_off", s_wb_stb, 4'b0000);
        check("ab_ack", m_wb_ack, 1'b0);
        check("ab_err", m_wb_err, 1'b0);
        request(32'h3001_0024, 32'h0000_005A, 4'h2, 1'b1);
        tick();
        check("ab2_stb", s_wb_stb, 4'b0010);
        check("ab2_sel", s_wb_sel, 4'h2);
        s_wb_ack = 4'b0010;
        tick();
        check("ab2_ack", m_wb_ack, 1'b1);
        release_bus();
        tick();

        // Reset pulsed mid-BUSY
        request(32'h3003_0000, 32'h1111_2222, 4'hF, 1'b1);
        tick();
        check("rb_stb", s_wb_stb, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        check("rb_stb_off", s_wb_stb, 4'b0000);
        check("rb_cyc_off", s_wb_cyc, 4'b0000);
        check("rb_adr",     s_wb_adr, 32'h0);
        check("rb_dat_w",   s_wb_dat_w, 32'h0);
        check("rb_ack",     m_wb_ack, 1'b0);
        check("rb_err",     m_wb_err, 1'b0);
        release_bus();
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("rb_no_replay", s_wb_stb, 4'b0000);
        check("rb_no_resp", m_wb_ack | m_wb_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_splitter_n.md
# wb_splitter_n

Parametrised Wishbone classic-cycle splitter connecting the single Caravel management Wishbone master port to `NUM_SLAVES` peripheral slaves, such as the CF_TMR32 PWM timers.
- Decodes the master address against per-slave base/mask pairs.
- Forwards one transaction at a time through a registered state machine.
- Returns data, ack or err to the master.
- Generates err itself for unmapped addresses and, optionally, for slave timeouts.

It sits in `user_project_wrapper` between the `wbs_*` ports and the peripheral instances.

## Interface
Parameters:
- `NUM_SLAVES`, 4: number of slave ports, 1..16.
- `AW`, 32: address width.
- `DW`, 32: data width, a multiple of 8.
- `BASE_ADDR`, {32'h3003_0000, 32'h3002_0000, 32'h3001_0000, 32'h3000_0000}: packed `NUM_SLAVES*AW`; slice i is the base of slave i.
- `ADDR_MASK`, 32'hFFFF_0000: decode mask applied to every slave.
- `TIMEOUT`, 255: BUSY cycles before a timeout error, ≥1; used only with `WB_SPLITTER_TIMEOUT_EN`.

Ports:
- `clk` input 1: clock (wb_clk_i).
- `rst` input 1: asynchronous active-high reset.
- `m_wb_adr` input AW; `m_wb_dat_w` input DW; `m_wb_sel` input DW/8; `m_wb_we` input 1; `m_wb_cyc` input 1; `m_wb_stb` input 1: master request.
- `m_wb_dat_r` output DW; `m_wb_ack` output 1; `m_wb_err` output 1: master response.
- `s_wb_adr` output AW; `s_wb_dat_w` output DW; `s_wb_sel` output DW/8; `s_wb_we` output 1: registered request, shared by all slaves.
- `s_wb_cyc` output NUM_SLAVES; `s_wb_stb` output NUM_SLAVES: per-slave, one-hot or zero.
- `s_wb_dat_r` input NUM_SLAVES*DW; `s_wb_ack` input NUM_SLAVES; `s_wb_err` input NUM_SLAVES: per-slave responses, slice i belongs to slave i.
- `timeout_o` output 1: one-cycle pulse on a timeout abort.

## Operation
- States are IDLE, BUSY and RESP. Reset state is IDLE.
- **IDLE:** on `m_wb_cyc & m_wb_stb`, register adr, dat_w, sel and we, and compute the decode.
  - Slave i matches when `(m_wb_adr & ADDR_MASK) == (BASE_ADDR[i] & ADDR_MASK)`. The lowest matching index wins.
  - Match: go to BUSY and latch the one-hot select.
  - No match: go to RESP with error.
- **BUSY:** `s_wb_cyc[sel]` and `s_wb_stb[sel]` are 1; every other bit is 0. Transitions, first matching rule wins:
  - `m_wb_cyc` deasserted: abort. Go to IDLE with no master response.
  - `s_wb_ack[sel]`: latch `s_wb_dat_r` slice `sel` into `m_wb_dat_r` and go to RESP with ack.
  - `s_wb_err[sel]`: go to RESP with error. `m_wb_dat_r` is 0.
  - Timeout (macro only): go to RESP with error and pulse `timeout_o`.
  - Ack and err asserted together: ack wins.
- **RESP:** drive `m_wb_ack` or `m_wb_err` for exactly one cycle, then go to IDLE. Slave strobes are 0.
- `m_wb_dat_r` holds its last value until the next ack, except on error, which drives it to 0.
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Reset asserted mid-transaction: slave strobes and the master response drop asynchronously, and nothing is replayed.
- Write data is never modified; `s_wb_sel` passes through unchanged.

## Timing
Edge numbering: edge E0 samples the master strobe in IDLE.
- Slave `stb` is high from after E0 until the edge that samples `ack` or `err`.
- `m_wb_ack` is high in the cycle after the slave ack is sampled.
- Master-visible latency is slave latency + 2 cycles. For a slave with zero-wait ack (ack in its first strobe cycle), `m_wb_ack` is high in cycle 3.
- An unmapped address gives `m_wb_err` in cycle 2.
- A new request is accepted in the IDLE cycle after RESP. The minimum spacing between transactions is therefore 3 cycles.
- The master must drop `stb` after sampling ack/err, per Wishbone classic. A request still present in IDLE is treated as new.
- Timeout counter:
  - Width is `$clog2(TIMEOUT+1)`.
  - Cleared on entry to BUSY; increments each BUSY cycle.
  - Fires on the edge where the count equals `TIMEOUT - 1`, so the slave strobe is high for exactly `TIMEOUT` cycles.
  - It cannot wrap, because it fires before saturation.

## Configuration
`WB_SPLITTER_TIMEOUT_EN`:
- **Defined:** timeout counter and `timeout_o` are present, and BUSY aborts after `TIMEOUT` cycles with `m_wb_err`.
- **Undefined:** no counter. BUSY waits indefinitely for ack/err or a master `cyc` drop. `timeout_o` is tied to 0.

## Test plan
- **Write slave 1:** adr 0x3001_0004, dat 0xDEAD_BEEF, sel 4'hF, we=1.
  - `s_wb_stb` = 4'b0010.
  - `s_wb_adr` and `s_wb_dat_w` equal the request.
  - Slave acks in its first strobe cycle, so `m_wb_ack` is high in cycle 3 for one cycle.
- **Read slave 3:** adr 0x3003_0008; slave 3 returns 0x1234_5678 after 4 wait cycles.
  - `m_wb_dat_r` = 0x1234_5678 with `m_wb_ack`, 6 cycles after E0.
  - Other slave data lanes are ignored.
- **Unmapped:** adr 0x3004_0000.
  - `s_wb_stb` stays 0.
  - `m_wb_err` is high for exactly one cycle, in cycle 2.
- **Timeout:** macro defined, `TIMEOUT`=8, slave 0 never responds.
  - `s_wb_stb[0]` is high for 8 cycles.
  - Then `m_wb_err` and `timeout_o` pulse.
  - Without the macro, no response after 1000 cycles.
- **Slave error and precedence:**
  - Slave 2 asserts err alone: `m_wb_err`=1 and `m_wb_dat_r`=0.
  - Slave 2 asserts ack and err together: `m_wb_ack` only.
- **Aborts:**
  - Master drops `cyc` in BUSY: the slave strobe drops on the next edge with no ack/err, and a following request succeeds.
  - `rst` pulsed mid-BUSY: all outputs read 0 within the reset cycle.
